// File: rtl/branch_cond_iter.sv
// branch_cond_iter: multi-cycle MSB-first branch comparator.
// Walks CHUNK bits per cycle and decodes funct3 into a taken flag.
// Ports:
//   clk, reset (sync, active-high), flush (sync kill)
//   in_valid/in_ready, a, b, funct3 : operand side
//   out_valid/out_ready             : result handshake
//   cout = {eq, gt_signed, gt_unsigned}
//   taken, illegal                  : funct3 decode
module branch_cond_iter #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       cout,
  output logic             taken,
  output logic             illegal
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad
    $error("WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } st_t;

  st_t st;
  st_t st_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       f3_q;
  logic [IW-1:0]    idx;
  logic             dseen;
  logic             ugt;

  logic [CHUNK-1:0] ach [N];
  logic [CHUNK-1:0] bch [N];
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic             cdiff;
  logic             last;
  logic             accept;
  logic             diff_n;
  logic             ugt_n;
  logic             eq_n;
  logic             gts_n;
  logic             tk_n;
  logic             ill_n;

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ach[k] = a_q[k*CHUNK +: CHUNK];
    assign bch[k] = b_q[k*CHUNK +: CHUNK];
  end

  assign ca     = ach[idx];
  assign cb     = bch[idx];
  assign cdiff  = ca != cb;
  assign last   = (cdiff && EARLY_EXIT != 0)
               || idx == '0;
  assign accept = in_valid && in_ready;

  // Once a difference is seen, later chunks
  // cannot change the ordering.
  assign diff_n = dseen || cdiff;
  assign ugt_n  = dseen ? ugt : (cdiff && ca > cb);
  assign eq_n   = !diff_n;

  // Differing sign bits decide signed order
  // regardless of the magnitude bits.
  assign gts_n = (a_q[WIDTH-1] ^ b_q[WIDTH-1])
               ? !a_q[WIDTH-1] : ugt_n;

  always_comb begin
    tk_n  = 1'b0;
    ill_n = 1'b0;
    unique case (1'b1)
      f3_q == 3'b000: tk_n = eq_n;
      f3_q == 3'b001: tk_n = !eq_n;
      f3_q == 3'b100: tk_n = !eq_n && !gts_n;
      f3_q == 3'b101: tk_n = eq_n || gts_n;
      f3_q == 3'b110: tk_n = !eq_n && !ugt_n;
      f3_q == 3'b111: tk_n = eq_n || ugt_n;
      default:        ill_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
    end else begin
      st <= st_n;
    end
  end

  always_comb begin
    st_n = st;
    if (flush) begin
      st_n = IDLE;
    end else begin
      unique case (st)
        IDLE:    if (accept)    st_n = CMP;
        CMP:     if (last)      st_n = DONE;
        DONE:    if (out_ready) st_n = IDLE;
        default:                st_n = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (st == IDLE) && !flush;
    out_valid = (st == DONE);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      b_q  <= b;
      f3_q <= funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= LAST;
      dseen   <= 1'b0;
      ugt     <= 1'b0;
      cout    <= 3'b000;
      taken   <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      idx   <= LAST;
      dseen <= 1'b0;
      ugt   <= 1'b0;
    end else if (st == CMP && !flush) begin
      if (last) begin
        cout    <= {eq_n, gts_n, ugt_n};
        taken   <= tk_n;
        illegal <= ill_n;
      end else begin
        idx   <= idx - IW'(1);
        dseen <= diff_n;
        ugt   <= ugt_n;
      end
    end
  end

endmodule

// File: tb/tb_branch_cond_iter.sv
// tb_branch_cond_iter: directed vectors for the 32/8 early-exit
// build, plus a 64/16 fixed-latency build with a model sweep.
module tb_branch_cond_iter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        aflush, av, ardy, aov, aor, atk, aill;
  logic [31:0] aa, ab;
  logic [2:0]  af3, acout;

  logic        bflush, bv, brdy, bov, bor, btk, bill;
  logic [63:0] ba, bb;
  logic [2:0]  bf3, bcout;

  int checks   = 0;
  int failures = 0;

  logic [2:0] legal [6] = '{3'b000, 3'b001, 3'b100,
                           3'b101, 3'b110, 3'b111};

  branch_cond_iter #(
    .WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)
  ) u_a (
    .clk(clk), .reset(reset), .flush(aflush),
    .in_valid(av), .in_ready(ardy),
    .a(aa), .b(ab), .funct3(af3),
    .out_valid(aov), .out_ready(aor),
    .cout(acout), .taken(atk), .illegal(aill)
  );

  branch_cond_iter #(
    .WIDTH(64), .CHUNK(16), .EARLY_EXIT(0)
  ) u_b (
    .clk(clk), .reset(reset), .flush(bflush),
    .in_valid(bv), .in_ready(brdy),
    .a(ba), .b(bb), .funct3(bf3),
    .out_valid(bov), .out_ready(bor),
    .cout(bcout), .taken(btk), .illegal(bill)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_tk(input logic [2:0] f,
                                  input logic [63:0] x,
                                  input logic [63:0] y);
    case (f)
      3'b000:  return x == y;
      3'b001:  return x != y;
      3'b100:  return $signed(x) < $signed(y);
      3'b101:  return $signed(x) >= $signed(y);
      3'b110:  return x < y;
      3'b111:  return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  task automatic start_a(input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [2:0] f);
    chk("a_rdy_pre", 64'(ardy), 64'd1);
    aa  = x;
    ab  = y;
    af3 = f;
    av  = 1'b1;
    @(negedge clk);
    av = 1'b0;
  endtask

  task automatic wait_a(output int lat);
    lat = 0;
    while (!aov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op_a(input string tag,
                      input logic [31:0] x,
                      input logic [31:0] y,
                      input logic [2:0] f,
                      input int el,
                      input logic [2:0] ec,
                      input logic et,
                      input logic ei);
    int lat;
    aor = 1'b1;
    start_a(x, y, f);
    wait_a(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(el));
    chk({tag, "_cout"}, 64'(acout), 64'(ec));
    chk({tag, "_tk"}, 64'(atk), 64'(et));
    chk({tag, "_ill"}, 64'(aill), 64'(ei));
    @(negedge clk);
    chk({tag, "_ovlo"}, 64'(aov), 64'd0);
    chk({tag, "_rdy"}, 64'(ardy), 64'd1);
  endtask

  task automatic op_b(input string tag,
                      input logic [63:0] x,
                      input logic [63:0] y,
                      input logic [2:0] f,
                      input int el,
                      input logic [2:0] ec,
                      input logic et,
                      input logic ei);
    int lat;
    bor = 1'b1;
    chk({tag, "_rdy_pre"}, 64'(brdy), 64'd1);
    ba  = x;
    bb  = y;
    bf3 = f;
    bv  = 1'b1;
    @(negedge clk);
    bv  = 1'b0;
    lat = 0;
    while (!bov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(el));
    chk({tag, "_cout"}, 64'(bcout), 64'(ec));
    chk({tag, "_tk"}, 64'(btk), 64'(et));
    chk({tag, "_ill"}, 64'(bill), 64'(ei));
    @(negedge clk);
    chk({tag, "_ovlo"}, 64'(bov), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [63:0] x;
    logic [63:0] y;
    logic [2:0]  f;

    reset  = 1'b1;
    aflush = 1'b0;
    av     = 1'b0;
    aor    = 1'b1;
    aa     = '0;
    ab     = '0;
    af3    = '0;
    bflush = 1'b0;
    bv     = 1'b0;
    bor    = 1'b1;
    ba     = '0;
    bb     = '0;
    bf3    = '0;
    repeat (3) @(negedge clk);

    chk("rst_ov", 64'(aov), 64'd0);
    chk("rst_cout", 64'(acout), 64'd0);
    chk("rst_tk", 64'(atk), 64'd0);
    chk("rst_ill", 64'(aill), 64'd0);
    chk("rst_b_cout", 64'(bcout), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 64'(ardy), 64'd1);

    op_a("t1", 32'h12345678, 32'h12345678, 3'b000,
         4, 3'b100, 1'b1, 1'b0);
    op_a("t2blt", 32'h80000000, 32'h00000001, 3'b100,
         1, 3'b001, 1'b1, 1'b0);
    op_a("t2bltu", 32'h80000000, 32'h00000001, 3'b110,
         1, 3'b001, 1'b0, 1'b0);
    op_b("t2ee0", 64'h8000000000000000, 64'd1, 3'b100,
         4, 3'b001, 1'b1, 1'b0);
    op_a("t3bge", 32'h000000FF, 32'h000000FE, 3'b101,
         4, 3'b011, 1'b1, 1'b0);
    op_a("t3bne", 32'h000000FF, 32'h000000FE, 3'b001,
         4, 3'b011, 1'b1, 1'b0);
    op_a("t3beq", 32'h00010000, 32'h00000000, 3'b000,
         2, 3'b011, 1'b0, 1'b0);
    op_b("tbkeep", 64'h0002000000000001,
         64'h0001000000000005, 3'b110,
         4, 3'b011, 1'b0, 1'b0);
    op_b("tbneg", 64'hFFFF000000000000,
         64'hFFFF000000000001, 3'b101,
         4, 3'b000, 1'b0, 1'b0);

    aor = 1'b0;
    start_a(32'h12345678, 32'h12345678, 3'b000);
    wait_a(lat);
    chk("t4_lat", 64'(lat), 64'd4);
    aa  = 32'd5;
    ab  = 32'd3;
    af3 = 3'b010;
    av  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_ov", 64'(aov), 64'd1);
      chk("t4_cout", 64'(acout), 64'(3'b100));
      chk("t4_tk", 64'(atk), 64'd1);
      chk("t4_rdy", 64'(ardy), 64'd0);
      @(negedge clk);
    end
    aor = 1'b1;
    @(negedge clk);
    chk("t4_ovlo", 64'(aov), 64'd0);
    chk("t4_rdy1", 64'(ardy), 64'd1);
    @(negedge clk);
    av = 1'b0;
    chk("t4_acc", 64'(ardy), 64'd0);
    wait_a(lat);
    chk("t5_lat", 64'(lat), 64'd4);
    chk("t5_cout", 64'(acout), 64'(3'b011));
    chk("t5_tk", 64'(atk), 64'd0);
    chk("t5_ill", 64'(aill), 64'd1);
    @(negedge clk);

    start_a(32'h12345678, 32'h12345678, 3'b000);
    @(negedge clk);
    aflush = 1'b1;
    @(negedge clk);
    aflush = 1'b0;
    #1;
    chk("t6a_rdy", 64'(ardy), 64'd1);
    chk("t6a_ov", 64'(aov), 64'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (aov) seen = 1;
    end
    chk("t6a_noov", 64'(seen), 64'd0);

    aa     = 32'd1;
    ab     = 32'd2;
    af3    = 3'b000;
    av     = 1'b1;
    aflush = 1'b1;
    #1;
    chk("t6b_rdy0", 64'(ardy), 64'd0);
    @(negedge clk);
    av     = 1'b0;
    aflush = 1'b0;
    #1;
    chk("t6b_rdy", 64'(ardy), 64'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (aov) seen = 1;
    end
    chk("t6b_noov", 64'(seen), 64'd0);

    aor = 1'b0;
    start_a(32'h80000000, 32'h00000001, 3'b100);
    wait_a(lat);
    chk("t6c_ov", 64'(aov), 64'd1);
    chk("t6c_tk", 64'(atk), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6c_ovlo", 64'(aov), 64'd0);
    chk("t6c_cout", 64'(acout), 64'd0);
    chk("t6c_tk0", 64'(atk), 64'd0);
    chk("t6c_ill", 64'(aill), 64'd0);
    reset = 1'b0;
    aor   = 1'b1;
    @(negedge clk);
    chk("t6c_ov2", 64'(aov), 64'd0);
    chk("t6c_rdy", 64'(ardy), 64'd1);

    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      case (i % 4)
        0:       y = {$urandom, $urandom};
        1:       y = x;
        2:       y = x ^ (64'd1 << $urandom_range(63, 0));
        default: y = {x[63:32], $urandom};
      endcase
      f = legal[i % 6];
      op_b("rnd", x, y, f, 4,
           {x == y, $signed(x) > $signed(y), x > y},
           ref_tk(f, x, y), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_cond_iter.md
Name: branch_cond_iter

Overview:
- Parametrised, multi-cycle successor to the combinational branch-condition comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per cycle.
- Stops early at the first differing chunk.
- Decodes the RISC-V branch funct3 into a taken flag.
- Sits between decode/execute and PC-select in the multi-cycle core, with valid/ready on both sides and a flush input for pipeline kill.

Parameters:
- WIDTH, 32: operand width in bits.
- CHUNK, 8: bits compared per cycle. WIDTH % CHUNK != 0 is an elaboration error.
- EARLY_EXIT, 1: 1 = finish at the first differing chunk; 0 = always examine all chunks (fixed latency).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of any in-flight or held operation.
- in_valid  in  1  operand/funct3 valid.
- in_ready  out  1  block can accept; high only in IDLE and only when flush=0.
- a  in  WIDTH  operand A; signed for BLT/BGE, unsigned for BLTU/BGEU.
- b  in  WIDTH  operand B.
- funct3  in  3  branch type.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- cout  out  3  compare flags:
  - [2] A==B
  - [1] A>B signed
  - [0] A>B unsigned
- taken  out  1  branch decision for funct3.
- illegal  out  1  funct3 is 010 or 011.

Behaviour:
- N = WIDTH/CHUNK. Chunk k = bits [k*CHUNK+CHUNK-1 : k*CHUNK]. Index counter is max($clog2(N),1) bits.
- States:
  - IDLE: in_ready=1.
  - CMP: examining chunks.
  - DONE: out_valid=1.
- Reset: state=IDLE and all outputs 0 (out_valid, cout, taken, illegal); index=N-1. Internal operand registers do not need resetting. Reset has priority over everything, including mid-CMP and DONE; an aborted op never produces out_valid.
- flush=1 (reset=0): next state IDLE and out_valid=0. No accept occurs in a flush cycle, even if in_valid=1.
- Accept: in_valid & in_ready at an edge latches a, b and funct3, sets index=N-1, and moves to CMP.
- CMP, one chunk per cycle, at chunk index:
  - If chunks differ and EARLY_EXIT=1, or index==0: go to DONE and register the flags.
  - Otherwise decrement index.
  - Track "first differing chunk" and ua_gt (A chunk > B chunk unsigned at that chunk). With EARLY_EXIT=0, keep the first difference found and ignore later chunks.
- Flags:
  - eq = no differing chunk.
  - gtu = ua_gt.
  - gt_signed = ~a[WIDTH-1] if a[WIDTH-1]!=b[WIDTH-1], else gtu.
  - cout = {eq, gt_signed, gtu}.
- Latency: out_valid rises m edges after the accepting edge, where m = number of chunks examined (1..N). With EARLY_EXIT=0, or with equal operands, m=N.
- Taken decode:
  - 000 BEQ: eq
  - 001 BNE: ~eq
  - 100 BLT: ~eq & ~gt_signed
  - 101 BGE: eq | gt_signed
  - 110 BLTU: ~eq & ~gtu
  - 111 BGEU: eq | gtu
  - 010/011: taken=0, illegal=1; cout is still valid.
- DONE: cout, taken and illegal are held stable while out_valid & ~out_ready. On out_valid & out_ready at an edge, go to IDLE, out_valid=0, and in_ready=1 in the next cycle. No accept happens in the same cycle as the DONE handshake (one op at a time, no overlap).
- Input changes during CMP/DONE are ignored, because operands are latched.
- Outputs other than out_valid may hold stale values in IDLE; the consumer qualifies them with out_valid.

Test Plan (WIDTH=32, CHUNK=8 unless noted):
1. a=b=0x12345678, funct3=000, out_ready=1 -> out_valid 4 edges after accept; cout=3'b100, taken=1, illegal=0; in_ready=1 the cycle after the handshake.
2. a=0x80000000, b=0x00000001, funct3=100 -> out_valid after 1 edge; cout=3'b001, taken=1. Repeat with funct3=110 -> taken=0. Repeat with EARLY_EXIT=0 -> same flags, latency 4.
3. a=0x000000FF, b=0x000000FE, funct3=101 -> difference found at chunk 0, latency 4; cout=3'b011, taken=1. Same operands with funct3=001 -> taken=1.
4. Backpressure: case 1 with out_ready=0 for 5 cycles -> out_valid, cout and taken stable, in_ready=0, a second in_valid not accepted. Then out_ready=1 -> IDLE next cycle, and the pending op is accepted the cycle after.
5. funct3=010, a=5, b=3 -> illegal=1, taken=0, cout=3'b011.
6. Kill paths:
   - flush at the 2nd CMP cycle of case 1 -> no out_valid ever, in_ready=1 next cycle.
   - flush together with in_valid in IDLE -> no accept.
   - reset asserted in DONE -> out_valid=0 next edge, all outputs 0.
   - WIDTH=64, CHUNK=16 sweep against a reference model on 1000 random pairs with all six legal funct3 values.
